// File: rtl/eth_frame_edit_pkg.sv
// Shared types and tuser field positions for the frame-edit run-time controller.
// The detector tuser carries one 17-bit slot per script plus a frame-level FCS flag in bit 0.
package eth_frame_edit_pkg;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } frame_state_e;

    localparam int SCRIPT_TUSER_STRIDE = 17;
    localparam int MATCHED_OFS         = 1;
    localparam int EDIT_TUSER_FCS      = 0;
    localparam int EDIT_TUSER_DROP     = 1;
    localparam int EDIT_TUSER_W        = 10;

    // Bit position of MATCHED for a given script inside the detector tuser.
    function automatic int matched_bit(input int script);
        return script * SCRIPT_TUSER_STRIDE + MATCHED_OFS;
    endfunction

endpackage

// File: rtl/eth_frame_edit_ctrl_sat_counter.sv
// Saturating statistics counter: sticks at all-ones, clear wins over increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != {W{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/eth_frame_edit_ctrl.sv
// Run-time controller for the frame-edit loop: frame-boundary-safe script mask updates
// plus per-script match statistics and editor output frame/drop/corrupt statistics.
module eth_frame_edit_ctrl
    import eth_frame_edit_pkg::*;
#(
    parameter int                       C_NUM_SCRIPTS = 4,
    parameter int                       C_CNT_WIDTH   = 32,
    parameter logic [C_NUM_SCRIPTS-1:0] C_RESET_MASK  = '0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 cfg_wr_en,
    input  logic [C_NUM_SCRIPTS-1:0]             cfg_wr_mask,
    output logic                                 cfg_busy,
    output logic                                 cfg_wr_ack,
    input  logic                                 cnt_clear,
    input  logic                                 mon_tvalid,
    input  logic                                 mon_tlast,
    input  logic [SCRIPT_TUSER_STRIDE*C_NUM_SCRIPTS:0] mon_tuser,
    input  logic                                 edit_tvalid,
    input  logic                                 edit_tlast,
    input  logic [EDIT_TUSER_W-1:0]              edit_tuser,
    output logic [C_NUM_SCRIPTS-1:0]             script_en,
    output logic [C_NUM_SCRIPTS*C_CNT_WIDTH-1:0] cnt_matched,
    output logic [C_CNT_WIDTH-1:0]               cnt_frames,
    output logic [C_CNT_WIDTH-1:0]               cnt_dropped,
    output logic [C_CNT_WIDTH-1:0]               cnt_corrupt
);

    frame_state_e               state_reg, state_next;
    logic [C_NUM_SCRIPTS-1:0]   script_en_reg;
    logic [C_NUM_SCRIPTS-1:0]   pending_mask_reg;
    logic                       pending_valid_reg;
    logic                       ack_reg;
    logic [C_NUM_SCRIPTS-1:0]   sticky_reg, sticky_next;
    logic [C_NUM_SCRIPTS-1:0]   beat_matched;
    logic [C_NUM_SCRIPTS-1:0]   match_inc;
    logic                       apply;
    logic                       edit_frame_end;
    logic                       frame_inc;
    logic                       drop_inc;
    logic                       corrupt_inc;
    logic                       unused_tuser_bits;

    // Most tuser fields belong to the detector/editor; only the flags are consumed here.
    assign unused_tuser_bits = ^{mon_tuser, edit_tuser};

    // ------------------------------------------------------------------
    // Frame tracking on the detector->editor stream
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     if (mon_tvalid && !mon_tlast) state_next = ST_IN_FRAME;
            ST_IN_FRAME: if (mon_tvalid && mon_tlast)  state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Mask update: only applied in a gap between frames, so the detector
    // never sees a script set change in the middle of a frame.
    // ------------------------------------------------------------------
    assign apply = (state_reg == ST_IDLE) && !mon_tvalid && pending_valid_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            script_en_reg     <= C_RESET_MASK;
            pending_mask_reg  <= '0;
            pending_valid_reg <= 1'b0;
            ack_reg           <= 1'b0;
        end else begin
            ack_reg <= apply;
            if (apply) begin
                script_en_reg <= pending_mask_reg;
            end
            // A write landing on the apply edge becomes the next pending update.
            if (cfg_wr_en) begin
                pending_mask_reg  <= cfg_wr_mask;
                pending_valid_reg <= 1'b1;
            end else if (apply) begin
                pending_valid_reg <= 1'b0;
            end
        end
    end

    assign script_en  = script_en_reg;
    assign cfg_busy   = pending_valid_reg;
    assign cfg_wr_ack = ack_reg;

    // ------------------------------------------------------------------
    // Per-script match statistics: one count per frame per script
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < C_NUM_SCRIPTS; gi++) begin : g_match
            assign beat_matched[gi] = mon_tuser[matched_bit(gi)];
            assign match_inc[gi]    = mon_tvalid && mon_tlast &&
                                      (sticky_reg[gi] || beat_matched[gi]);

            sat_counter #(
                .W (C_CNT_WIDTH)
            ) u_cnt_matched (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (cnt_clear),
                .inc   (match_inc[gi]),
                .cnt   (cnt_matched[gi*C_CNT_WIDTH +: C_CNT_WIDTH])
            );
        end
    endgenerate

    always_comb begin
        sticky_next = sticky_reg;
        if (mon_tvalid) begin
            if (mon_tlast) begin
                sticky_next = '0;
            end else begin
                sticky_next = sticky_reg | beat_matched;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_reg <= '0;
        end else begin
            sticky_reg <= sticky_next;
        end
    end

    // ------------------------------------------------------------------
    // Editor output statistics, flags sampled on the last beat only
    // ------------------------------------------------------------------
    assign edit_frame_end = edit_tvalid && edit_tlast;
    assign frame_inc      = edit_frame_end;
    assign drop_inc       = edit_frame_end && edit_tuser[EDIT_TUSER_DROP];
    assign corrupt_inc    = edit_frame_end && !edit_tuser[EDIT_TUSER_DROP] &&
                            edit_tuser[EDIT_TUSER_FCS];

    sat_counter #(
        .W (C_CNT_WIDTH)
    ) u_cnt_frames (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clear),
        .inc   (frame_inc),
        .cnt   (cnt_frames)
    );

    sat_counter #(
        .W (C_CNT_WIDTH)
    ) u_cnt_dropped (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clear),
        .inc   (drop_inc),
        .cnt   (cnt_dropped)
    );

    sat_counter #(
        .W (C_CNT_WIDTH)
    ) u_cnt_corrupt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clear),
        .inc   (corrupt_inc),
        .cnt   (cnt_corrupt)
    );

endmodule
